mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 146 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Word-by-word RAM copy/fill engine driving a single-port RAM.
// Copy alternates READ/WRITE per word; fill issues one WRITE per word.
module mem_copy_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_SPACE = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_SPACE-1:0] src_addr,
    input  logic [ADDR_SPACE-1:0] dst_addr,
    input  logic [ADDR_SPACE-1:0] length,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_SPACE-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_SPACE-1:0] ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_SPACE-1:0] src_q, src_d;
    logic [ADDR_SPACE-1:0] dst_q, dst_d;
    logic [ADDR_SPACE-1:0] rem_q, rem_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wren_q, wren_d;
    logic [ADDR_SPACE-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        hold_d  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = length;
                    mode_d = mode;
                    fill_d = fill_value;
                    if (length == '0) begin
                        state_d = DONE;
                    end else if (mode) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                hold_d  = mem_q;
                state_d = WRITE;
            end
            WRITE: begin
                src_d = src_q + ONE;
                dst_d = dst_q + ONE;
                rem_d = rem_q - ONE;
                if (rem_q == ONE) begin
                    state_d = DONE;
                end else if (mode_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the next state.
        busy_d = (state_d == READ) || (state_d == WRITE);
        done_d = (state_d == DONE);
        wren_d = (state_d == WRITE);
        addr_d = '0;
        data_d = '0;
        if (state_d == READ) begin
            addr_d = src_d;
        end
        if (state_d == WRITE) begin
            addr_d = dst_d;
            data_d = mode_d ? fill_d : hold_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_wren    = wren_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: vector table of whole jobs plus
// hand sequences for abort, start-while-busy and held start.
module tb_mem_copy_engine;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [15:0] fill;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;

    logic [15:0] ram [0:65535];
    logic        pk_en;
    logic [15:0] pk_addr;
    logic [15:0] pk_data;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        mode;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        logic [15:0] fill;
        logic [15:0] d0;
        logic [15:0] dlast;
        logic [31:0] done_c;
        logic [31:0] nwr;
    } vec_t;

    vec_t vecs [7];

    mem_copy_engine #(.DATA_WIDTH(16), .ADDR_SPACE(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src),
        .dst_addr   (dst),
        .length     (len),
        .fill_value (fill),
        .busy       (busy),
        .done       (done),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    always #5 clock = ~clock;

    assign mem_q = ram[mem_address];

    // RAM commits mid-cycle so a write is complete before any later reset.
    always @(negedge clock) begin
        if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end else if (pk_en) begin
            ram[pk_addr] <= pk_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pk_addr = a;
        pk_data = d;
        pk_en = 1'b1;
        @(negedge clock);
        #1;
        pk_en = 1'b0;
    endtask

    task automatic run_job(input logic m, input logic [15:0] s,
                           input logic [15:0] d, input logic [15:0] l,
                           input logic [15:0] f, input int inj,
                           output int done_c, output int nwr,
                           output int nbusy, output int oerr,
                           output logic post_ok);
        int nrd;
        done_c = 0;
        nwr = 0;
        nbusy = 0;
        oerr = 0;
        nrd = 0;
        @(negedge clock);
        mode = m;
        src = s;
        dst = d;
        len = l;
        fill = f;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (c == inj) begin
                start = 1'b1;
                mode = ~m;
                src = 16'h0200;
                dst = 16'h0090;
                len = 16'h0002;
                fill = 16'hEEEE;
            end else begin
                start = 1'b0;
            end
            if (busy) nbusy++;
            if (mem_wren) begin
                if (mem_address !== 16'(d + nwr)) oerr++;
                nwr++;
            end else if (busy) begin
                if (mem_address !== 16'(s + nrd)) oerr++;
                nrd++;
            end
            if (done) begin
                done_c = c;
                break;
            end
        end
        start = 1'b0;
        @(negedge clock);
        post_ok = !done && !busy && !mem_wren &&
                  (mem_address == 16'h0) && (mem_data == 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dc, nw, nb, oe, ndone, last_done, nwr_h;
        logic pok;
        logic [15:0] a;

        vecs[0] = '{1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0000,
                    16'h00A1, 16'h00D4, 32'd9, 32'd4};
        vecs[1] = '{1'b1, 16'h0000, 16'h0020, 16'd3, 16'h5A5A,
                    16'h5A5A, 16'h5A5A, 32'd4, 32'd3};
        vecs[2] = '{1'b0, 16'hFFFE, 16'h0100, 16'd4, 16'h0000,
                    16'h1111, 16'h4444, 32'd9, 32'd4};
        vecs[3] = '{1'b0, 16'h0010, 16'h0050, 16'd0, 16'h0000,
                    16'h0000, 16'h0000, 32'd1, 32'd0};
        vecs[4] = '{1'b1, 16'h0000, 16'h0058, 16'd0, 16'h9999,
                    16'h0000, 16'h0000, 32'd1, 32'd0};
        vecs[5] = '{1'b1, 16'h0000, 16'hFFFF, 16'd1, 16'h0BAD,
                    16'h0BAD, 16'h0BAD, 32'd2, 32'd1};
        vecs[6] = '{1'b0, 16'h0030, 16'h0031, 16'd2, 16'h0000,
                    16'h0C0C, 16'h0C0C, 32'd5, 32'd2};

        for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
        pk_en = 1'b0;
        pk_addr = 16'h0;
        pk_data = 16'h0;
        reset_n = 1'b0;
        start = 1'b1;
        mode = 1'b0;
        src = 16'h0;
        dst = 16'h0;
        len = 16'h4;
        fill = 16'h0;

        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_wren", {31'b0, mem_wren}, 32'd0);
        start = 1'b0;
        poke(16'h0010, 16'h00A1);
        poke(16'h0011, 16'h00B2);
        poke(16'h0012, 16'h00C3);
        poke(16'h0013, 16'h00D4);
        poke(16'hFFFE, 16'h1111);
        poke(16'hFFFF, 16'h2222);
        poke(16'h0000, 16'h3333);
        poke(16'h0001, 16'h4444);
        poke(16'h0030, 16'h0C0C);
        poke(16'h0031, 16'h0D0D);
        check("rst_addr", {16'b0, mem_address}, 32'd0);
        check("rst_data", {16'b0, mem_data}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len,
                    vecs[i].fill, 0, dc, nw, nb, oe, pok);
            check($sformatf("v%0d_done_cycle", i), dc, vecs[i].done_c);
            check($sformatf("v%0d_writes", i), nw, vecs[i].nwr);
            check($sformatf("v%0d_busy_cycles", i), nb,
                  vecs[i].done_c - 1);
            check($sformatf("v%0d_addr_order", i), oe, 32'd0);
            check($sformatf("v%0d_post_idle", i), {31'b0, pok}, 32'd1);
            check($sformatf("v%0d_ram_first", i),
                  {16'b0, ram[vecs[i].dst]}, {16'b0, vecs[i].d0});
            a = vecs[i].dst + vecs[i].len - 16'd1;
            check($sformatf("v%0d_ram_last", i),
                  {16'b0, ram[a]}, {16'b0, vecs[i].dlast});
        end
        check("copy_mid1", {16'b0, ram[16'h0041]}, 32'h00B2);
        check("wrap_mid", {16'b0, ram[16'h0102]}, 32'h3333);
        check("fill_mid", {16'b0, ram[16'h0021]}, 32'h5A5A);

        run_job(1'b0, 16'h0010, 16'h0080, 16'd4, 16'h0, 3,
                dc, nw, nb, oe, pok);
        check("busy_start_done", dc, 32'd9);
        check("busy_start_writes", nw, 32'd4);
        check("busy_start_order", oe, 32'd0);
        check("busy_start_ram80", {16'b0, ram[16'h0080]}, 32'h00A1);
        check("busy_start_ram83", {16'b0, ram[16'h0083]}, 32'h00D4);
        check("busy_start_ram90", {16'b0, ram[16'h0090]}, 32'h0000);

        @(negedge clock);
        mode = 1'b1;
        dst = 16'h00A0;
        len = 16'd1;
        fill = 16'h1234;
        start = 1'b1;
        ndone = 0;
        last_done = 0;
        nwr_h = 0;
        @(posedge clock);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (done) begin
                ndone++;
                last_done = c;
            end
            if (mem_wren) nwr_h++;
            if (c == 5) start = 1'b0;
        end
        check("hold_start_dones", ndone, 32'd2);
        check("hold_start_writes", nwr_h, 32'd2);
        check("hold_start_2nd_done", last_done, 32'd5);

        @(negedge clock);
        mode = 1'b0;
        src = 16'h0010;
        dst = 16'h0060;
        len = 16'd4;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        nwr_h = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            if (mem_wren) nwr_h++;
        end
        check("abort_pre_writes", nwr_h, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_wren", {31'b0, mem_wren}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_addr", {16'b0, mem_address}, 32'd0);
        ndone = 0;
        nwr_h = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (c == 2) reset_n = 1'b1;
            if (done) ndone++;
            if (mem_wren) nwr_h++;
        end
        check("abort_no_done", ndone, 32'd0);
        check("abort_no_writes", nwr_h, 32'd0);
        check("abort_ram60", {16'b0, ram[16'h0060]}, 32'h00A1);
        check("abort_ram61", {16'b0, ram[16'h0061]}, 32'h00B2);
        check("abort_ram62", {16'b0, ram[16'h0062]}, 32'h0000);

        run_job(1'b1, 16'h0, 16'h0070, 16'd2, 16'h7777, 0,
                dc, nw, nb, oe, pok);
        check("fresh_done", dc, 32'd3);
        check("fresh_writes", nw, 32'd2);
        check("fresh_ram71", {16'b0, ram[16'h0071]}, 32'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
